reg_wb: RTL and testbench

Writeback sequencer that drives the write port and branch inputs of the CPU register file. It accepts single-word, byte and load-multiple writeback requests over a valid/ready handshake. Load-multiple requests are expanded into one register write per incoming data beat, in ascending register order. Writes to the PC index are converted into branch requests on `ib`/`bv`, so the PC is never written through `we`.

---
 rtl/reg_wb_if.sv | 27 ++
 rtl/reg_wb.sv | 140 ++++++++++++++
 tb/tb_reg_wb.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_if.sv
// reg_wb_if: request and multi-beat data handshakes into the writeback sequencer.
// master drives req_*/mem_* payload and valids; slave returns req_ready/mem_ready.
interface reg_wb_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                       req_valid;
    logic                       req_ready;
    logic [1:0]                 req_kind;
    logic [ADDR_WIDTH-1:0]      req_addr;
    logic [(1<<ADDR_WIDTH)-1:0] req_list;
    logic [31:0]                req_data;
    logic                       mem_valid;
    logic                       mem_ready;
    logic [31:0]                mem_data;

    modport master (
        output req_valid, req_kind, req_addr, req_list, req_data,
        output mem_valid, mem_data,
        input  req_ready, mem_ready
    );

    modport slave (
        input  req_valid, req_kind, req_addr, req_list, req_data,
        input  mem_valid, mem_data,
        output req_ready, mem_ready
    );
endinterface

// File: rtl/reg_wb.sv
// reg_wb: register-file writeback sequencer (word, byte, load-multiple, PC redirect).
// Ports: clk, reset (async active-low), bus (reg_wb_if.slave), we/wa/wd, ib/bv, err, busy.
module reg_wb #(
    parameter int ADDR_WIDTH = 4,
    parameter int PC_ADDR    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_wb_if.slave               bus,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [31:0]           wd,
    output logic                  ib,
    output logic [31:0]           bv,
    output logic                  err,
    output logic                  busy
);
    localparam int LW = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC = ADDR_WIDTH'(PC_ADDR);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LW-1:0]         r_pend;
    logic [LW-1:0]         w_pend_nxt;
    logic [ADDR_WIDTH-1:0] w_low;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_data;
    logic                  w_err;
    logic                  w_pc;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_wa;
    logic [31:0]           r_wd;
    logic                  r_ib;
    logic [31:0]           r_bv;
    logic                  r_err;

    assign bus.req_ready = (r_state == IDLE);
    assign bus.mem_ready = (r_state == BURST);
    assign busy          = (r_state == BURST);

    assign we  = r_we;
    assign wa  = r_wa;
    assign wd  = r_wd;
    assign ib  = r_ib;
    assign bv  = r_bv;
    assign err = r_err;

    // Scanning downward leaves the lowest set bit of the pending mask.
    always_comb begin
        w_low = '0;
        for (int i = LW - 1; i >= 0; i--) begin
            if (r_pend[i]) w_low = ADDR_WIDTH'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_wr        = 1'b0;
        w_addr      = '0;
        w_data      = '0;
        w_err       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    unique case (bus.req_kind)
                        2'b00: begin
                            w_wr   = 1'b1;
                            w_addr = bus.req_addr;
                            w_data = bus.req_data;
                        end
                        2'b01: begin
                            w_wr   = 1'b1;
                            w_addr = bus.req_addr;
                            w_data = {24'b0, bus.req_data[7:0]};
                        end
                        2'b10: begin
                            if (bus.req_list != '0) begin
                                w_pend_nxt  = bus.req_list;
                                w_state_nxt = BURST;
                            end
                        end
                        default: w_err = 1'b1;
                    endcase
                end
            end
            BURST: begin
                if (bus.mem_valid) begin
                    w_wr       = 1'b1;
                    w_addr     = w_low;
                    w_data     = bus.mem_data;
                    // Clear the lowest set bit.
                    w_pend_nxt = r_pend & (r_pend - LW'(1));
                    if (w_pend_nxt == '0) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_pc = (w_addr == PC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // PC-targeted writes go out on the branch path; wa/wd keep the last real write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we  <= 1'b0;
            r_wa  <= '0;
            r_wd  <= '0;
            r_ib  <= 1'b0;
            r_bv  <= '0;
            r_err <= 1'b0;
        end else begin
            r_we  <= w_wr & ~w_pc;
            r_ib  <= w_wr & w_pc;
            r_bv  <= (w_wr & w_pc) ? w_data : 32'h0;
            r_err <= w_err;
            if (w_wr & ~w_pc) begin
                r_wa <= w_addr;
                r_wd <= w_data;
            end
        end
    end
endmodule

// File: tb/tb_reg_wb.sv
// tb_reg_wb: directed-vector bench for reg_wb.
// Drives stimulus #1 after each rising edge and checks registered outputs there.
module tb_reg_wb;
    logic        clk;
    logic        reset;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        ib;
    logic [31:0] bv;
    logic        err;
    logic        busy;
    int          total;
    int          bad;

    reg_wb_if #(.ADDR_WIDTH(4)) bus ();

    reg_wb #(.ADDR_WIDTH(4), .PC_ADDR(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ib    (ib),
        .bv    (bv),
        .err   (err),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_kind  = 2'b00;
        bus.req_addr  = 4'd0;
        bus.req_list  = 16'h0;
        bus.req_data  = 32'h0;
        bus.mem_valid = 1'b0;
        bus.mem_data  = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        step();
        step();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_we got %b want 0", we); end
        total++; if (wa !== 4'd0) begin bad++; $display("FAIL rst_wa got %h want 0", wa); end
        total++; if (wd !== 32'h0) begin bad++; $display("FAIL rst_wd got %h want 0", wd); end
        total++; if (ib !== 1'b0) begin bad++; $display("FAIL rst_ib got %b want 0", ib); end
        total++; if (bv !== 32'h0) begin bad++; $display("FAIL rst_bv got %h want 0", bv); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_rready got %b want 1", bus.req_ready); end
        total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL rst_mready got %b want 0", bus.mem_ready); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'b00;
        bus.req_addr  = 4'd3;
        bus.req_data  = 32'hDEADBEEF;
        step();
        total++; if (we !== 1'b1) begin bad++; $display("FAIL word_we got %b want 1", we); end
        total++; if (wa !== 4'd3) begin bad++; $display("FAIL word_wa got %h want 3", wa); end
        total++; if (wd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_wd got %h want deadbeef", wd); end
        bus.req_kind = 2'b01;
        bus.req_addr = 4'd4;
        bus.req_data = 32'h123456A5;
        step();
        total++; if (we !== 1'b1) begin bad++; $display("FAIL byte_we got %b want 1", we); end
        total++; if (wa !== 4'd4) begin bad++; $display("FAIL byte_wa got %h want 4", wa); end
        total++; if (wd !== 32'h000000A5) begin bad++; $display("FAIL byte_wd got %h want 000000a5", wd); end
        idle_inputs();
        step();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL b2b_we_drop got %b want 0", we); end
        total++; if (wa !== 4'd4) begin bad++; $display("FAIL b2b_wa_hold got %h want 4", wa); end
        total++; if (wd !== 32'h000000A5) begin bad++; $display("FAIL b2b_wd_hold got %h want a5", wd); end
    endtask

    task automatic test_multi();
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'b10;
        bus.req_list  = 16'h8025;
        step();
        idle_inputs();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mul_busy got %b want 1", busy); end
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL mul_rready got %b want 0", bus.req_ready); end
        total++; if (bus.mem_ready !== 1'b1) begin bad++; $display("FAIL mul_mready got %b want 1", bus.mem_ready); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL mul_accept_we got %b want 0", we); end
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'h11;
        step();
        total++; if ({we, wa, wd} !== {1'b1, 4'd0, 32'h11}) begin bad++; $display("FAIL mul_b0 got we=%b wa=%h wd=%h want 1 0 11", we, wa, wd); end
        bus.mem_data = 32'h22;
        step();
        total++; if ({we, wa, wd} !== {1'b1, 4'd2, 32'h22}) begin bad++; $display("FAIL mul_b1 got we=%b wa=%h wd=%h want 1 2 22", we, wa, wd); end
        bus.mem_valid = 1'b0;
        step();
        total++; if (we !== 1'b0 || ib !== 1'b0) begin bad++; $display("FAIL mul_gap got we=%b ib=%b want 0 0", we, ib); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mul_gap_busy got %b want 1", busy); end
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'h33;
        step();
        total++; if ({we, wa, wd} !== {1'b1, 4'd5, 32'h33}) begin bad++; $display("FAIL mul_b2 got we=%b wa=%h wd=%h want 1 5 33", we, wa, wd); end
        bus.mem_data = 32'h44;
        step();
        total++; if ({we, ib, bv} !== {1'b0, 1'b1, 32'h44}) begin bad++; $display("FAIL mul_pc got we=%b ib=%b bv=%h want 0 1 44", we, ib, bv); end
        total++; if (wa !== 4'd5) begin bad++; $display("FAIL mul_pc_wa got %h want 5", wa); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL mul_end_rready got %b want 1", bus.req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_end_busy got %b want 0", busy); end
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'h99;
        step();
        total++; if (we !== 1'b0 || ib !== 1'b0) begin bad++; $display("FAIL mul_after got we=%b ib=%b want 0 0", we, ib); end
        idle_inputs();
    endtask

    task automatic test_pc_redirect();
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'b00;
        bus.req_addr  = 4'd15;
        bus.req_data  = 32'h00000100;
        step();
        total++; if ({we, ib, bv} !== {1'b0, 1'b1, 32'h100}) begin bad++; $display("FAIL pcw got we=%b ib=%b bv=%h want 0 1 100", we, ib, bv); end
        bus.req_kind = 2'b01;
        bus.req_data = 32'hFFFFFF80;
        step();
        total++; if ({we, ib, bv} !== {1'b0, 1'b1, 32'h80}) begin bad++; $display("FAIL pcb got we=%b ib=%b bv=%h want 0 1 80", we, ib, bv); end
        idle_inputs();
        step();
        total++; if (ib !== 1'b0 || bv !== 32'h0) begin bad++; $display("FAIL pc_drop got ib=%b bv=%h want 0 0", ib, bv); end
    endtask

    task automatic test_empty_reserved();
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'b10;
        bus.req_list  = 16'h0;
        step();
        total++; if ({we, ib, err, busy} !== 4'b0000) begin bad++; $display("FAIL empty got we=%b ib=%b err=%b busy=%b want 0000", we, ib, err, busy); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL empty_rready got %b want 1", bus.req_ready); end
        bus.req_kind = 2'b11;
        step();
        total++; if ({we, ib, err} !== 3'b001) begin bad++; $display("FAIL rsv got we=%b ib=%b err=%b want 001", we, ib, err); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rsv_rready got %b want 1", bus.req_ready); end
        idle_inputs();
        step();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rsv_drop got %b want 0", err); end
    endtask

    task automatic test_reset_mid_burst();
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'b10;
        bus.req_list  = 16'h000E;
        step();
        idle_inputs();
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'hAA;
        step();
        total++; if ({we, wa, wd} !== {1'b1, 4'd1, 32'hAA}) begin bad++; $display("FAIL rmb_b0 got we=%b wa=%h wd=%h want 1 1 aa", we, wa, wd); end
        bus.mem_data = 32'hBB;
        reset = 1'b0;
        #1;
        total++; if ({we, wa, wd, ib, bv, err, busy} !== 71'h0) begin bad++; $display("FAIL rmb_outs got we=%b wa=%h wd=%h ib=%b bv=%h err=%b busy=%b want all 0", we, wa, wd, ib, bv, err, busy); end
        total++; if ({bus.req_ready, bus.mem_ready} !== 2'b10) begin bad++; $display("FAIL rmb_ready got %b%b want 10", bus.req_ready, bus.mem_ready); end
        step();
        reset = 1'b1;
        step();
        total++; if (we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmb_post0 got we=%b busy=%b want 0 0", we, busy); end
        step();
        total++; if (we !== 1'b0 || bus.mem_ready !== 1'b0) begin bad++; $display("FAIL rmb_post1 got we=%b mready=%b want 0 0", we, bus.mem_ready); end
        bus.mem_valid = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'b00;
        bus.req_addr  = 4'd6;
        bus.req_data  = 32'h55;
        step();
        total++; if ({we, wa, wd} !== {1'b1, 4'd6, 32'h55}) begin bad++; $display("FAIL rmb_word got we=%b wa=%h wd=%h want 1 6 55", we, wa, wd); end
        idle_inputs();
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_back_to_back();
        test_multi();
        test_pc_redirect();
        test_empty_reserved();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
